pixel_fifo_packer: RTL and testbench

//  Output-side stage feeding the result FIFO drained by the image writer. Accepts
//  the processed pixel stream (valid/ready with sof/eof markers) and buffers it in a
//  2-entry skid pipeline. Pushes frame-aligned words into the FIFO and tracks

---
 rtl/pixel_fifo_packer_if.sv | 24 ++
 rtl/pixel_fifo_packer.sv | 151 +++++++++++++++
 tb/tb_pixel_fifo_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fifo_packer_if.sv
// Pixel stream input and result-FIFO write port of pixel_fifo_packer.
// slave is the packer's view; master is the surrounding source/FIFO side.
interface pixel_fifo_packer_if #(
   parameter int DWIDTH = 24
);
   logic              in_valid;
   logic              in_ready;
   logic [DWIDTH-1:0] in_data;
   logic              in_sof;
   logic              in_eof;
   logic              fifo_wrreq;
   logic [DWIDTH-1:0] fifo_data;
   logic              fifo_full;

   modport slave (
      input  in_valid, in_data, in_sof, in_eof, fifo_full,
      output in_ready, fifo_wrreq, fifo_data
   );

   modport master (
      output in_valid, in_data, in_sof, in_eof, fifo_full,
      input  in_ready, fifo_wrreq, fifo_data
   );
endinterface

// File: rtl/pixel_fifo_packer.sv
// Frame-aligned 2-slot skid pipeline from the pixel stream into the result FIFO.
// Define FRAME_CHECK_EN to build the frame-length checker that drives err_len.
module pixel_fifo_packer #(
   parameter int DWIDTH = 24
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [10:0]        width,
   input  logic [10:0]        height,
   input  logic [10:0]        num_frame,
   pixel_fifo_packer_if.slave bus,
   output logic [10:0]        frame_cnt,
   output logic               busy,
   output logic               done,
   output logic               err_len
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   state_t            state;
   logic [DWIDTH-1:0] out_reg;
   logic [DWIDTH-1:0] skid_reg;
   logic              out_valid;
   logic              skid_valid;
   logic [21:0]       pix_cnt;

   logic              accept;
   logic              keep;
   logic              pop;
   logic [DWIDTH-1:0] out_n;
   logic [DWIDTH-1:0] skid_n;
   logic              out_valid_n;
   logic              skid_valid_n;
   logic [21:0]       pix_base;
   logic [21:0]       pix_inc;
   logic [10:0]       frame_inc;
   logic              last_frame;
   logic              err_n;

   assign accept         = bus.in_valid & bus.in_ready;
   assign keep           = accept & ((state == ACTIVE) | ((state == IDLE) & bus.in_sof));
   assign pop            = out_valid & ~bus.fifo_full;
   assign bus.fifo_wrreq = pop;
   assign bus.fifo_data  = out_reg;

   assign pix_base   = bus.in_sof ? '0 : pix_cnt;
   assign pix_inc    = (&pix_base) ? pix_base : pix_base + 22'd1;
   assign frame_inc  = frame_cnt + 11'd1;
   assign last_frame = (num_frame != 11'd0) && (frame_inc == num_frame);

   // in_ready is low whenever skid_reg is occupied, so a push never meets a full skid.
   always_comb begin
      out_n        = out_reg;
      skid_n       = skid_reg;
      out_valid_n  = out_valid;
      skid_valid_n = skid_valid;
      if (skid_valid) begin
         if (pop) begin
            out_n        = skid_reg;
            skid_valid_n = 1'b0;
         end
      end else if (keep && (pop || !out_valid)) begin
         out_n       = bus.in_data;
         out_valid_n = 1'b1;
      end else if (keep) begin
         skid_n       = bus.in_data;
         skid_valid_n = 1'b1;
      end else if (pop) begin
         out_valid_n = 1'b0;
      end
   end

`ifdef FRAME_CHECK_EN
   logic [21:0] frame_area;
   assign frame_area = width * height;

   always_comb begin
      err_n = 1'b0;
      if (keep) begin
         err_n = ((state == ACTIVE) & bus.in_sof) |
                 (bus.in_eof ? (pix_inc != frame_area) : (pix_inc == frame_area));
      end
   end
`else
   logic unused_frame_cfg;
   assign unused_frame_cfg = ^{width, height};
   assign err_n            = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         out_reg      <= '0;
         skid_reg     <= '0;
         out_valid    <= 1'b0;
         skid_valid   <= 1'b0;
         pix_cnt      <= '0;
         frame_cnt    <= '0;
         bus.in_ready <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_len      <= 1'b0;
      end else begin
         out_reg    <= out_n;
         skid_reg   <= skid_n;
         out_valid  <= out_valid_n;
         skid_valid <= skid_valid_n;
         err_len    <= err_n;
         case (state)
            IDLE, ACTIVE: begin
               if (keep && bus.in_eof) begin
                  frame_cnt <= frame_inc;
                  pix_cnt   <= '0;
                  busy      <= 1'b0;
                  if (last_frame) begin
                     state        <= DRAIN;
                     bus.in_ready <= 1'b0;
                  end else begin
                     state        <= IDLE;
                     bus.in_ready <= enable & ~skid_valid_n;
                  end
               end else if (keep) begin
                  pix_cnt      <= pix_inc;
                  state        <= ACTIVE;
                  busy         <= 1'b1;
                  bus.in_ready <= ~skid_valid_n;
               end else begin
                  busy         <= (state == ACTIVE);
                  bus.in_ready <= ~skid_valid_n & ((state == ACTIVE) | enable);
               end
            end
            DRAIN: begin
               bus.in_ready <= 1'b0;
               busy         <= 1'b0;
               if (!out_valid && !skid_valid) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               bus.in_ready <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_fifo_packer.sv
// Self-checking bench for pixel_fifo_packer: a directed vector table, directed
// sequences and randomized frames checked against a queue-based reference model.
module tb_pixel_fifo_packer;

   localparam int DW = 24;

   typedef enum int {M_IDLE, M_ACTIVE, M_DRAIN, M_DONE} mstate_t;

   typedef struct {
      logic        v, s, e;
      logic [23:0] d;
      logic        f;
      logic        ready, wr;
      logic [23:0] wdata;
      logic [10:0] fc;
      logic        busy, done;
   } vec_t;

   typedef struct {
      logic [23:0] d;
      logic        s, e;
   } word_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [10:0] width = 11'd4;
   logic [10:0] height = 11'd2;
   logic [10:0] num_frame = 11'd0;
   logic [10:0] frame_cnt;
   logic        busy, done, err_len;

   pixel_fifo_packer_if #(.DWIDTH(DW)) bus ();

   pixel_fifo_packer #(.DWIDTH(DW)) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .width    (width),
      .height   (height),
      .num_frame(num_frame),
      .bus      (bus.slave),
      .frame_cnt(frame_cnt),
      .busy     (busy),
      .done     (done),
      .err_len  (err_len)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [DW-1:0] mq[$];
   mstate_t       mst = M_IDLE;
   int            mframes = 0;
   int            mpix = 0;
   logic          mready = 1'b0;
   logic          merr = 1'b0;
   int            wr_count = 0;
   int            err_count = 0;

   logic          r_acc, r_wr, r_sof, r_eof;
   logic [DW-1:0] r_data;
   int            r_qsz;

   word_t stim[$];
   vec_t  tab[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic v, input logic s, input logic e, input logic [23:0] d,
                        input logic f);
      bus.in_valid  = v;
      bus.in_sof    = s;
      bus.in_eof    = e;
      bus.in_data   = d;
      bus.fifo_full = f;
      #1;
   endtask

   function automatic void model_step();
      int area, cnt;
      logic e;
      area = int'(width) * int'(height);
      if (r_wr && mq.size() != 0) void'(mq.pop_front());
      merr = 1'b0;
      if (mst == M_DRAIN && r_qsz == 0) begin
         mst = M_DONE;
      end else if (r_acc && (mst == M_ACTIVE || (mst == M_IDLE && r_sof))) begin
         cnt = (r_sof ? 0 : mpix) + 1;
         if (cnt > 4194303) cnt = 4194303;
         e = (r_sof && mst == M_ACTIVE) || (r_eof ? (cnt != area) : (cnt == area));
`ifdef FRAME_CHECK_EN
         merr = e;
`endif
         mq.push_back(r_data);
         if (r_eof) begin
            mframes++;
            mpix = 0;
            mst = (num_frame != 11'd0 && (mframes % 2048) == int'(num_frame)) ? M_DRAIN : M_IDLE;
         end else begin
            mpix = cnt;
            mst  = M_ACTIVE;
         end
      end
      mready = (mst == M_ACTIVE || (mst == M_IDLE && enable)) && mq.size() < 2;
   endfunction

   task automatic tick();
      logic exp_wr;
      chk("in_ready", 32'(bus.in_ready), 32'(mready));
      chk("frame_cnt", 32'(frame_cnt), 32'(mframes % 2048));
      chk("busy", 32'(busy), 32'(mst == M_ACTIVE));
      chk("done", 32'(done), 32'(mst == M_DONE));
      chk("err_len", 32'(err_len), 32'(merr));
      exp_wr = (mq.size() != 0) && !bus.fifo_full;
      chk("fifo_wrreq", 32'(bus.fifo_wrreq), 32'(exp_wr));
      if (bus.fifo_wrreq === 1'b1 && mq.size() != 0)
         chk("fifo_data", 32'(bus.fifo_data), 32'(mq[0]));
      r_acc  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      r_wr   = (bus.fifo_wrreq === 1'b1);
      r_sof  = bus.in_sof;
      r_eof  = bus.in_eof;
      r_data = bus.in_data;
      r_qsz  = mq.size();
      if (r_wr) wr_count++;
      if (err_len === 1'b1) err_count++;
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic idle(input int n, input logic f);
      for (int i = 0; i < n; i++) begin
         apply(1'b0, 1'b0, 1'b0, 24'h0, f);
         tick();
      end
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_eof   = 1'b0;
      bus.in_data  = '0;
      #2;
      reset = 1'b1;
      bus.fifo_full = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_fifo_wrreq", 32'(bus.fifo_wrreq), 32'd0);
      chk("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);
      mq.delete();
      mst = M_IDLE;
      mframes = 0;
      mpix = 0;
      mready = 1'b0;
      merr = 1'b0;
      wr_count = 0;
      err_count = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic add_frame(input int n, input int junk, input logic has_eof);
      word_t w;
      for (int i = 0; i < junk; i++) begin
         w.d = 24'($urandom);
         w.s = 1'b0;
         w.e = 1'b0;
         stim.push_back(w);
      end
      for (int i = 0; i < n; i++) begin
         w.d = 24'($urandom);
         w.s = (i == 0);
         w.e = has_eof && (i == n - 1);
         stim.push_back(w);
      end
   endtask

   // mode 0: no stalls, 1: fifo_full over [fa, fa+fn), 2: random valid and full
   task automatic send(input int mode, input int fa, input int fn);
      int   cyc, waits, idx;
      logic v, f, acc;
      cyc = 0;
      waits = 0;
      idx = 0;
      while (idx < stim.size()) begin
         if (mst == M_DRAIN || mst == M_DONE) break;
         v = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         f = (mode == 1) ? (cyc >= fa && cyc < fa + fn) :
             (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
         apply(v, stim[idx].s, stim[idx].e, stim[idx].d, f);
         acc = v && (bus.in_ready === 1'b1);
         tick();
         cyc++;
         if (acc) begin
            idx++;
            waits = 0;
         end else if (++waits > 200) begin
            chk("send_timeout", 32'(waits), 32'd0);
            break;
         end
      end
      stim.delete();
   endtask

   task automatic wait_drain(input int maxc);
      int n;
      n = 0;
      while (mq.size() != 0 && n < maxc) begin
         apply(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
         tick();
         n++;
      end
      chk("drain_timeout", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_eof    = 1'b0;
      bus.in_data   = '0;
      bus.fifo_full = 1'b0;
      @(negedge clock);

      // 1: vector table, two 4x2 frames back to back, num_frame=2
      for (int k = 0; k < 20; k++) begin
         tab[k].v     = (k < 16);
         tab[k].s     = (k == 0 || k == 8);
         tab[k].e     = (k == 7 || k == 15);
         tab[k].d     = (k < 16) ? 24'($urandom) : 24'h0;
         tab[k].f     = 1'b0;
         tab[k].ready = (k < 16);
         tab[k].wr    = (k >= 1 && k <= 16);
         tab[k].wdata = (k >= 1) ? tab[k-1].d : 24'h0;
         tab[k].fc    = (k < 8) ? 11'd0 : (k < 16) ? 11'd1 : 11'd2;
         tab[k].busy  = (k >= 1 && k <= 7) || (k >= 9 && k <= 15);
         tab[k].done  = (k >= 18);
      end
      width = 11'd4; height = 11'd2; num_frame = 11'd2; enable = 1'b1;
      do_reset();
      idle(1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         apply(tab[k].v, tab[k].s, tab[k].e, tab[k].d, tab[k].f);
         chk("t1_in_ready", 32'(bus.in_ready), 32'(tab[k].ready));
         chk("t1_fifo_wrreq", 32'(bus.fifo_wrreq), 32'(tab[k].wr));
         if (tab[k].wr) chk("t1_fifo_data", 32'(bus.fifo_data), 32'(tab[k].wdata));
         chk("t1_frame_cnt", 32'(frame_cnt), 32'(tab[k].fc));
         chk("t1_busy", 32'(busy), 32'(tab[k].busy));
         chk("t1_done", 32'(done), 32'(tab[k].done));
         chk("t1_err_len", 32'(err_len), 32'd0);
         tick();
      end
      chk("t1_writes", 32'(wr_count), 32'd16);

      // 2: same stream with a 5-cycle FIFO stall in the middle of frame 1
      width = 11'd4; height = 11'd2; num_frame = 11'd2; enable = 1'b1;
      do_reset();
      add_frame(8, 0, 1'b1);
      add_frame(8, 0, 1'b1);
      send(1, 4, 5);
      wait_drain(50);
      idle(3, 1'b0);
      chk("t2_writes", 32'(wr_count), 32'd16);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
      chk("t2_done", 32'(done), 32'd1);

      // 3: enable held low, then 3 words without sof before a valid frame
      width = 11'd4; height = 11'd2; num_frame = 11'd1; enable = 1'b0;
      do_reset();
      apply(1'b1, 1'b1, 1'b0, 24'h123456, 1'b0);
      tick();
      apply(1'b1, 1'b1, 1'b0, 24'h123456, 1'b0);
      tick();
      enable = 1'b1;
      add_frame(8, 3, 1'b1);
      send(0, 0, 0);
      wait_drain(50);
      idle(3, 1'b0);
      chk("t3_writes", 32'(wr_count), 32'd8);
      chk("t3_done", 32'(done), 32'd1);

      // 4: eof on the 6th word of a 4x2 frame
      width = 11'd4; height = 11'd2; num_frame = 11'd0; enable = 1'b1;
      do_reset();
      add_frame(6, 0, 1'b1);
      send(0, 0, 0);
      wait_drain(50);
      idle(2, 1'b0);
      chk("t4_writes", 32'(wr_count), 32'd6);
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd1);
`ifdef FRAME_CHECK_EN
      chk("t4_err_pulses", 32'(err_count), 32'd1);
`else
      chk("t4_err_pulses", 32'(err_count), 32'd0);
`endif

      // 5: reset while both slots hold words under fifo_full
      width = 11'd4; height = 11'd2; num_frame = 11'd0; enable = 1'b1;
      do_reset();
      idle(1, 1'b1);
      apply(1'b1, 1'b1, 1'b0, 24'hAAAAAA, 1'b1);
      tick();
      apply(1'b1, 1'b0, 1'b0, 24'h555555, 1'b1);
      tick();
      chk("t5_buffered", 32'(mq.size()), 32'd2);
      do_reset();
      add_frame(0, 3, 1'b0);
      send(0, 0, 0);
      idle(4, 1'b0);
      chk("t5_writes", 32'(wr_count), 32'd0);

      // 6: unlimited frames
      width = 11'd2; height = 11'd2; num_frame = 11'd0; enable = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) add_frame(4, 0, 1'b1);
      send(0, 0, 0);
      wait_drain(50);
      idle(3, 1'b0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_writes", 32'(wr_count), 32'd12);

      // randomized frames, lengths, stalls and framing errors
      for (int r = 0; r < 12; r++) begin
         int area, n;
         width = 11'($urandom_range(1, 4));
         height = 11'($urandom_range(1, 3));
         num_frame = 11'($urandom_range(0, 3));
         enable = 1'b1;
         area = int'(width) * int'(height);
         do_reset();
         for (int fr = 0; fr < 4; fr++) begin
            n = area;
            if ($urandom_range(0, 3) == 0) n = int'($urandom_range(1, area + 1));
            add_frame(n, int'($urandom_range(0, 2)), $urandom_range(0, 4) != 0);
         end
         send(2, 0, 0);
         wait_drain(100);
         idle(4, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
